// File: rtl/gol_pkg.sv
// Shared types and helpers for the Game-of-Life sequencer.
// Board geometry defaults, FSM states and wrap/seed helpers.
package gol_pkg;

    localparam int GOL_WIDTH     = 10;
    localparam int GOL_HEIGHT    = 9;
    localparam int INJ_ROW_FIRST = 3;
    localparam int INJ_ROW_LAST  = 5;
    localparam int MAX_CELLS     = 1024;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        WAIT_VB,
        COMMIT
    } state_t;

    function automatic int wrap_dec(int i, int n);
        return (i == 0) ? n - 1 : i - 1;
    endfunction

    function automatic int wrap_inc(int i, int n);
        return (i == n - 1) ? 0 : i + 1;
    endfunction

    // Glider heading down-right; w is the board width.
    function automatic logic [MAX_CELLS-1:0] glider_seed(int w);
        logic [MAX_CELLS-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return (one << (6 * w + 6))
             | (one << (7 * w + 7))
             | (one << (8 * w + 5))
             | (one << (8 * w + 6))
             | (one << (8 * w + 7));
    endfunction

endpackage

// File: rtl/gol_cell_rule.sv
// B3/S23 next-state rule for a single cell.
// Purely combinational; fed by the sequencer's neighbour mux.
module gol_cell_rule (
    input  logic [7:0] nbrs,
    input  logic       alive,
    output logic       alive_next
);

    logic [3:0] cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, nbrs[i]};
        end
        alive_next = (cnt == 4'd3) || ((cnt == 4'd2) && alive);
    end

endmodule

// File: rtl/gol_sequencer.sv
// Owns the committed board and steps one generation at a time.
// Cells are evaluated one per cycle into a shadow, committed in vblank.
module gol_sequencer
    import gol_pkg::*;
#(
    parameter int WIDTH    = GOL_WIDTH,
    parameter int HEIGHT   = GOL_HEIGHT,
    parameter int TICK_DIV = 16777216,
    parameter int GEN_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    step,
    input  logic                    load,
    input  logic [WIDTH*HEIGHT-1:0] load_data,
    input  logic [2:0]              left,
    input  logic [2:0]              right,
    input  logic                    vblank,
    output logic [WIDTH*HEIGHT-1:0] board,
    output logic [GEN_W-1:0]        gen_count,
    output logic                    busy,
    output logic                    gen_done
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int IW = $clog2(N);
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);
    localparam int TW = $clog2(TICK_DIV);

    localparam logic [MAX_CELLS-1:0] SEED_ALL = glider_seed(WIDTH);
    localparam logic [N-1:0]         SEED     = SEED_ALL[N-1:0];

    state_t         state;
    logic [N-1:0]   shadow;
    logic [IW-1:0]  idx;
    logic [RW-1:0]  row;
    logic [CW-1:0]  col;
    logic [TW-1:0]  tick;
    logic           pending;

    logic [7:0]     nbrs;
    logic           self_bit;
    logic           next_bit;
    logic           trigger;
    logic           go;
    logic           last_cell;
    logic [N-1:0]   inj_board;

    // Neighbours always come from the committed board, wrapped toroidally.
    always_comb begin
        int r, c, rn, rs, cw, ce;
        r  = int'(row);
        c  = int'(col);
        rn = wrap_dec(r, HEIGHT);
        rs = wrap_inc(r, HEIGHT);
        cw = wrap_dec(c, WIDTH);
        ce = wrap_inc(c, WIDTH);
        nbrs[0]  = board[IW'(rn * WIDTH + cw)];
        nbrs[1]  = board[IW'(rn * WIDTH + c)];
        nbrs[2]  = board[IW'(rn * WIDTH + ce)];
        nbrs[3]  = board[IW'(r * WIDTH + cw)];
        nbrs[4]  = board[IW'(r * WIDTH + ce)];
        nbrs[5]  = board[IW'(rs * WIDTH + cw)];
        nbrs[6]  = board[IW'(rs * WIDTH + c)];
        nbrs[7]  = board[IW'(rs * WIDTH + ce)];
        self_bit = board[idx];
    end

    gol_cell_rule u_rule (
        .nbrs       (nbrs),
        .alive      (self_bit),
        .alive_next (next_bit)
    );

    always_comb begin
        inj_board = shadow;
        for (int r = INJ_ROW_FIRST; r <= INJ_ROW_LAST; r++) begin
            inj_board[IW'(r * WIDTH)] =
                left[2'(r - INJ_ROW_FIRST)];
            inj_board[IW'(r * WIDTH + WIDTH - 1)] =
                right[2'(r - INJ_ROW_FIRST)];
        end
    end

    // Trigger fires as the count would reach TICK_DIV-1.
    assign trigger   = run && (state == IDLE)
                    && (tick == TW'(TICK_DIV - 2));
    assign go        = trigger || pending || step;
    assign last_cell = (idx == IW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            board     <= SEED;
            shadow    <= '0;
            gen_count <= '0;
            gen_done  <= 1'b0;
            busy      <= 1'b0;
            tick      <= '0;
            pending   <= 1'b0;
            idx       <= '0;
            row       <= '0;
            col       <= '0;
            state     <= IDLE;
        end else if (load) begin
            board     <= load_data;
            gen_count <= '0;
            gen_done  <= 1'b0;
            busy      <= 1'b0;
            tick      <= '0;
            pending   <= 1'b0;
            idx       <= '0;
            row       <= '0;
            col       <= '0;
            state     <= IDLE;
        end else begin
            gen_done <= 1'b0;
            if (!run) begin
                tick <= '0;
            end else if (state == IDLE) begin
                tick <= trigger ? '0 : tick + 1'b1;
            end
            if (step && state != IDLE) begin
                pending <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (go) begin
                        pending <= 1'b0;
                        busy    <= 1'b1;
                        idx     <= '0;
                        row     <= '0;
                        col     <= '0;
                        state   <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    shadow[idx] <= next_bit;
                    if (last_cell) begin
                        state <= WAIT_VB;
                    end else begin
                        idx <= idx + 1'b1;
                        if (col == CW'(WIDTH - 1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                WAIT_VB: begin
                    if (vblank) begin
                        board     <= inj_board;
                        gen_count <= gen_count + 1'b1;
                        gen_done  <= 1'b1;
                        state     <= COMMIT;
                    end
                end
                COMMIT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gol_sequencer.md
Name: gol_sequencer

Overview:
- Controller that owns the Game-of-Life board state and sequences generation updates.
- Triggers generations from a programmable tick divider or from single-step commands.
- Walks the board one cell per cycle through a rule sub-module into a shadow buffer, then commits during video blanking so the renderer never shows a half-updated board.
- Sits between the control inputs (run/step/load, paddle edge columns) and the pixel renderer; exports the flat board and a generation counter.

Parameters:
- WIDTH, 10, board columns.
- HEIGHT, 9, board rows.
- TICK_DIV, 16777216, clk cycles between auto generations when run=1 (minimum 2).
- GEN_W, 16, generation counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- run  in  1  level; auto-advance enabled.
- step  in  1  pulse; request one generation.
- load  in  1  pulse; replace board with load_data.
- load_data  in  WIDTH*HEIGHT  board image; bit r*WIDTH+c is cell (r,c).
- left  in  3  injected cells (3..5, 0).
- right  in  3  injected cells (3..5, WIDTH-1).
- vblank  in  1  level from video timing; commit permitted.
- board  out  WIDTH*HEIGHT  committed board, same bit order.
- gen_count  out  GEN_W  committed generations since reset/load.
- busy  out  1  high in COMPUTE, WAIT_VB and COMMIT.
- gen_done  out  1  one-cycle pulse after each commit.

Behaviour:
- Reset:
  - board = glider {(6,6),(7,7),(8,5),(8,6),(8,7)}, all other cells 0.
  - gen_count=0, gen_done=0, busy=0, tick counter=0, pending=0, state IDLE.
- Tick counter:
  - Counts only while run=1 and state IDLE.
  - On reaching TICK_DIV-1: wraps to 0 and raises a trigger.
  - Holds its value while busy; clears when run=0.
- step pulse sets pending (1 deep; extra pulses while pending are dropped). Triggers and pending behave the same.
- IDLE:
  - If trigger or pending: clear pending, go to COMPUTE, cell index=0.
- COMPUTE:
  - One cell per cycle, row-major, index 0..WIDTH*HEIGHT-1.
  - Neighbours use toroidal wrap (row -1 maps to HEIGHT-1, column WIDTH maps to 0).
  - Rule B3/S23; the result is written to the shadow bit at the same index.
  - After the last index: go to WAIT_VB. Duration is exactly WIDTH*HEIGHT cycles.
- WAIT_VB:
  - When vblank=1 (including the first WAIT_VB cycle): go to COMMIT.
- COMMIT (1 cycle):
  - At the clock edge: board <= shadow, with cells (3..5,0) forced to left[0..2] and (3..5,WIDTH-1) forced to right[0..2], sampled that cycle.
  - gen_count increments, wrapping at 2^GEN_W.
  - Next state IDLE; gen_done=1 in the following cycle only.
- Reads during COMPUTE always use the committed board; the board never changes outside COMMIT, load or rst.
- load:
  - Has priority over everything except rst, in any state.
  - board <= load_data (no injection), gen_count=0, pending=0, tick=0.
  - Aborts any generation in progress back to IDLE with no gen_done.
- step and load in the same cycle: load wins and step is dropped.
- rst in any state restores reset values on the next edge.
- Trigger latency: trigger/step seen in IDLE at edge N gives COMPUTE from N+1 and commit at edge N+1+WIDTH*HEIGHT+k, where k is the number of WAIT_VB cycles with vblank=0.
- busy=1 from the first COMPUTE cycle through the COMMIT cycle.

Decomposition:
- gol_pkg holds:
  - the state enum {IDLE, COMPUTE, WAIT_VB, COMMIT};
  - WIDTH/HEIGHT defaults and the injection row constants (3..5);
  - a function that returns the glider seed image;
  - wrap-index helper functions.
- Sub-module gol_cell_rule: combinational.
  - Inputs: the 8 neighbour bits and the current cell bit.
  - Output: next-state bit (popcount==3, or popcount==2 and cell alive).
  - Instantiated once and fed by the cell-index mux.
- The sequencer holds the FSM, counters, shadow register and injection logic.

Test Plan:
- Blinker: load cells (4,3),(4,4),(4,5); left=right=0; vblank=1; step → commit 1+90 cycles after step, board = (3,4),(4,4),(5,4), gen_count=1, one gen_done. A second step restores the horizontal blinker, gen_count=2.
- Glider wrap: reset, left=right=0, vblank=1, 4 steps → board = (7,7),(8,8),(0,6),(0,7),(0,8), gen_count=4.
- Vblank hold: vblank=0, step → busy stays 1 and board unchanged for 200 cycles after COMPUTE ends; raising vblank commits on the next edge, and gen_done follows one cycle later.
- Auto run: TICK_DIV=100, run=1, vblank=1 → gen_done pulses every 100+90+1 cycles. Dropping run → no further generations, and the tick counter reads 0.
- Injection and load abort:
  - left=3'b111, right=3'b000, empty board, step → cells (3..5,0)=1 after commit.
  - load of an empty board mid-COMPUTE → IDLE next cycle, board all 0, gen_count=0, no gen_done.
- Step collision: two steps during COMPUTE → exactly one extra generation. step with load in the same cycle → no generation.
